// File: rtl/direction_input_pkg.sv
// Shared game definitions: direction and turn-FSM encodings, press payload and
// the button-to-direction priority encoder.
package direction_input_pkg;

  localparam int unsigned DIR_W  = 2;
  localparam int unsigned BTN_N  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LINE_W = 10;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [DIR_W-1:0] dir;
  } press_t;

  // Opposite direction: up<->down, left<->right.
  function automatic logic [DIR_W-1:0] reverse_of(input logic [DIR_W-1:0] d);
    return d ^ 2'b10;
  endfunction

  // Lowest button index wins when several rise together.
  function automatic press_t press_encode(input logic [BTN_N-1:0] rise);
    press_t p;
    p.valid = |rise;
    if (rise[0])      p.dir = DIR_UP;
    else if (rise[1]) p.dir = DIR_LEFT;
    else if (rise[2]) p.dir = DIR_DOWN;
    else              p.dir = DIR_RIGHT;
    return p;
  endfunction

endpackage

// File: rtl/direction_input_btn_debounce.sv
// Frame-rate debouncer for one synchronised button; flags a 0->1 flip of the
// debounced state in the tick cycle that causes it.
module btn_debounce
  import direction_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic level,
  output logic rise_c
);

  logic             state;
  logic [CNT_W-1:0] cnt;
  logic             flip_c;

  assign flip_c = tick && (level != state) &&
                  ((cnt + CNT_W'(1)) == CNT_W'(DEBOUNCE_FRAMES));
  assign rise_c = flip_c && !state;

  // Counter only advances on frame ticks while the level disagrees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= 1'b0;
      cnt   <= '0;
    end else if (tick) begin
      if (level == state) begin
        cnt <= '0;
      end else if (flip_c) begin
        state <= ~state;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/direction_input.sv
// Player direction control: synchronises and debounces the four buttons once
// per frame, then applies reversals immediately and queues perpendicular turns.
module direction_input
  import direction_input_pkg::*;
#(
  parameter int unsigned FRAME_LINE      = 480,
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned PENDING_FRAMES  = 8,
  parameter logic [1:0]  INIT_DIR        = 2'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  svpos,
  input  logic [3:0]  btn,
  input  logic        turn_ok,
  output logic [1:0]  direction,
  output logic        pending_valid,
  output logic        turn_strobe
);

  logic [BTN_N-1:0] btn_s1;
  logic [BTN_N-1:0] btn_s2;
  logic             line_q;
  logic             frame_tick_c;
  logic [BTN_N-1:0] rise_c;
  press_t           press_q;

  state_e           state;
  state_e           state_n;
  logic [DIR_W-1:0] pend_dir;
  logic [DIR_W-1:0] pend_dir_n;
  logic [CNT_W-1:0] age;
  logic [CNT_W-1:0] age_n;
  logic [DIR_W-1:0] dir_n;
  logic             strobe_n;

  // Two-flop synchroniser for the raw buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

  // Resetting line_q high suppresses a tick if reset releases on the frame line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) line_q <= 1'b1;
    else        line_q <= (svpos == LINE_W'(FRAME_LINE));
  end

  assign frame_tick_c = (svpos == LINE_W'(FRAME_LINE)) && !line_q;

  for (genvar g = 0; g < BTN_N; g++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (frame_tick_c),
      .level  (btn_s2[g]),
      .rise_c (rise_c[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q <= '0;
    end else if (frame_tick_c) begin
      press_q <= press_encode(rise_c);
    end else begin
      press_q <= '0;
    end
  end

  // A press can never share a cycle with a tick, so press handling goes first.
  always_comb begin
    state_n    = state;
    pend_dir_n = pend_dir;
    age_n      = age;
    dir_n      = direction;
    strobe_n   = 1'b0;
    if (press_q.valid) begin
      if (press_q.dir == direction) begin
        state_n    = ST_IDLE;
        pend_dir_n = '0;
        age_n      = '0;
      end else if (press_q.dir == reverse_of(direction)) begin
        dir_n      = press_q.dir;
        strobe_n   = 1'b1;
        state_n    = ST_IDLE;
        pend_dir_n = '0;
        age_n      = '0;
      end else begin
        pend_dir_n = press_q.dir;
        age_n      = '0;
        state_n    = ST_PENDING;
      end
    end else begin
      case (state)
        ST_PENDING: begin
          if (frame_tick_c) begin
            if (turn_ok) begin
              dir_n      = pend_dir;
              strobe_n   = 1'b1;
              state_n    = ST_IDLE;
              pend_dir_n = '0;
              age_n      = '0;
            end else if ((age + CNT_W'(1)) == CNT_W'(PENDING_FRAMES)) begin
              state_n    = ST_IDLE;
              pend_dir_n = '0;
              age_n      = '0;
            end else begin
              age_n = age + CNT_W'(1);
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pend_dir      <= '0;
      age           <= '0;
      direction     <= INIT_DIR;
      turn_strobe   <= 1'b0;
      pending_valid <= 1'b0;
    end else begin
      state         <= state_n;
      pend_dir      <= pend_dir_n;
      age           <= age_n;
      direction     <= dir_n;
      turn_strobe   <= strobe_n;
      pending_valid <= (state_n == ST_PENDING);
    end
  end

endmodule
